// File: rtl/uart_rx_fifo_if.sv
// Interface between the UART receive buffer and its surroundings.
// Carries receiver unload handshake, host read port and status.
interface uart_rx_fifo_if #(
    parameter int ADDR_W = 4
);
    logic              unload_en;
    logic              flush;
    logic              rx_empty_i;
    logic [7:0]        rx_data_i;
    logic              uld_rx_data;
    logic              rd_en;
    logic [7:0]        rd_data;
    logic              fifo_empty;
    logic              fifo_full;
    logic [ADDR_W:0]   level;
    logic              stalled;

    modport master (
        output unload_en, flush, rx_empty_i, rx_data_i, rd_en,
        input  uld_rx_data, rd_data, fifo_empty, fifo_full,
        input  level, stalled
    );

    modport slave (
        input  unload_en, flush, rx_empty_i, rx_data_i, rd_en,
        output uld_rx_data, rd_data, fifo_empty, fifo_full,
        output level, stalled
    );
endinterface

// File: rtl/uart_rx_fifo.sv
// Unloads bytes from the UART receiver into a first-word-fall-through
// FIFO, holding bytes in the receiver while the FIFO has no room.
module uart_rx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input logic          reset,
    input logic          rxclk,
    uart_rx_fifo_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE,
        UNLOAD,
        CAPTURE
    } state_t;

    localparam logic [ADDR_W+1:0] DEPTH_O = (ADDR_W + 2)'(DEPTH);
    localparam logic [ADDR_W:0]   DEPTH_L = (ADDR_W + 1)'(DEPTH);

    state_t              state;
    state_t              state_nxt;
    logic [7:0]          mem [DEPTH];
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_ptr;
    logic [ADDR_W:0]     level;
    logic [ADDR_W+1:0]   occ;
    logic                inflight;
    logic                room;
    logic                pending;
    logic                start;
    logic                wr;
    logic                rd;
    logic                uld;
    logic                stalled;

    // Occupancy includes the byte already committed to by an unload.
    always_comb begin
        inflight = (state != IDLE);
        occ      = {1'b0, level} + {{(ADDR_W + 1){1'b0}}, inflight};
        room     = (occ < DEPTH_O);
        pending  = bus.unload_en & ~bus.rx_empty_i;
        wr       = (state == CAPTURE) & ~bus.flush;
        rd       = bus.rd_en & (level != '0) & ~bus.flush;
    end

    // State register of the unload sequencer.
    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic: one strobe, then one capture cycle per byte.
    always_comb begin
        state_nxt = state;
        start     = 1'b0;
        unique case (state)
            IDLE: begin
                if (pending && room && !bus.flush) begin
                    state_nxt = UNLOAD;
                    start     = 1'b1;
                end
            end
            UNLOAD:  state_nxt = CAPTURE;
            CAPTURE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        if (bus.flush) state_nxt = IDLE;
    end

    // Registered unload strobe, high only during UNLOAD.
    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) uld <= 1'b0;
        else       uld <= start;
    end

    // Byte storage; contents need no reset.
    always_ff @(posedge rxclk) begin
        if (wr) mem[wr_ptr] <= bus.rx_data_i;
    end

    // Pointers and occupancy; flush overrides all traffic.
    always_ff @(posedge rxclk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (bus.flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr) wr_ptr <= wr_ptr + 1'b1;
            if (rd) rd_ptr <= rd_ptr + 1'b1;
            unique case ({wr, rd})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Sticky record that a byte had to wait for FIFO space.
    always_ff @(posedge rxclk or posedge reset) begin
        if (reset)                                stalled <= 1'b0;
        else if (bus.flush)                       stalled <= 1'b0;
        else if (state == IDLE && pending && !room) stalled <= 1'b1;
    end

    assign bus.uld_rx_data = uld;
    assign bus.rd_data     = mem[rd_ptr];
    assign bus.fifo_empty  = (level == '0);
    assign bus.fifo_full   = (level == DEPTH_L);
    assign bus.level       = level;
    assign bus.stalled     = stalled;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with a small UART receiver model.
// Each step drives inputs, advances the clock and asserts expectations.
module tb_uart_rx_fifo;

    logic reset;
    logic rxclk;

    uart_rx_fifo_if #(.ADDR_W(4)) bus ();

    uart_rx_fifo #(
        .DEPTH (16),
        .ADDR_W(4)
    ) dut (
        .reset(reset),
        .rxclk(rxclk),
        .bus  (bus)
    );

    int checks;
    int errors;
    int strobes;
    logic [7:0] rxq [$];
    logic [7:0] outq [$];

    initial rxclk = 1'b0;
    always #5 rxclk = ~rxclk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // One clock; receiver model answers a sampled strobe at the edge.
    task automatic tick();
        logic u;
        u = bus.uld_rx_data;
        @(posedge rxclk);
        #1;
        if (u) begin
            strobes++;
            if (rxq.size() > 0) bus.rx_data_i = rxq.pop_front();
        end
        bus.rx_empty_i = (rxq.size() == 0);
    endtask

    task automatic push_rx(input logic [7:0] b);
        rxq.push_back(b);
        bus.rx_empty_i = 1'b0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic pop();
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
    endtask

    task automatic do_flush();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
    endtask

    initial begin
        int maxl;
        checks        = 0;
        errors        = 0;
        strobes       = 0;
        reset         = 1'b1;
        bus.unload_en = 1'b0;
        bus.flush     = 1'b0;
        bus.rx_empty_i = 1'b1;
        bus.rx_data_i = 8'h00;
        bus.rd_en     = 1'b0;
        #12;
        chk("rst_uld", 32'(bus.uld_rx_data), 0);
        chk("rst_empty", 32'(bus.fifo_empty), 1);
        chk("rst_full", 32'(bus.fifo_full), 0);
        chk("rst_level", 32'(bus.level), 0);
        chk("rst_stalled", 32'(bus.stalled), 0);
        reset = 1'b0;
        bus.unload_en = 1'b1;
        tick();

        // single byte
        push_rx(8'hA5);
        tick();
        chk("t1_uld_hi", 32'(bus.uld_rx_data), 1);
        tick();
        chk("t1_uld_lo", 32'(bus.uld_rx_data), 0);
        chk("t1_lvl0", 32'(bus.level), 0);
        tick();
        chk("t1_lvl1", 32'(bus.level), 1);
        chk("t1_nempty", 32'(bus.fifo_empty), 0);
        chk("t1_data", 32'(bus.rd_data), 32'hA5);
        pop();
        chk("t1_lvl_pop", 32'(bus.level), 0);
        chk("t1_empty", 32'(bus.fifo_empty), 1);

        // fill to full
        strobes = 0;
        for (int i = 0; i <= 16; i++) push_rx(8'(i));
        ticks(60);
        chk("t2_level", 32'(bus.level), 16);
        chk("t2_full", 32'(bus.fifo_full), 1);
        chk("t2_strobes", 32'(strobes), 16);
        chk("t2_stalled", 32'(bus.stalled), 1);
        chk("t2_head", 32'(bus.rd_data), 0);
        pop();
        ticks(6);
        chk("t2_strobes17", 32'(strobes), 17);
        chk("t2_level_refill", 32'(bus.level), 16);
        for (int i = 1; i <= 16; i++) begin
            chk($sformatf("t2_rd%0d", i), 32'(bus.rd_data), 32'(i));
            pop();
        end
        chk("t2_drained", 32'(bus.fifo_empty), 1);
        do_flush();
        chk("t2_stall_clr", 32'(bus.stalled), 0);

        // wrap-around with slower host
        for (int i = 0; i < 40; i++) push_rx(8'(8'h40 + i));
        maxl = 0;
        for (int c = 0; c < 2000 && outq.size() < 40; c++) begin
            if (c % 4 == 0 && !bus.fifo_empty) begin
                outq.push_back(bus.rd_data);
                bus.rd_en = 1'b1;
            end
            tick();
            bus.rd_en = 1'b0;
            if (int'(bus.level) > maxl) maxl = int'(bus.level);
        end
        chk("t3_count", 32'(outq.size()), 40);
        chk("t3_maxlvl_ok", 32'(maxl <= 16), 1);
        for (int i = 0; i < outq.size(); i++)
            chk($sformatf("t3_seq%0d", i), 32'(outq[i]), 32'(8'h40 + i));
        chk("t3_empty", 32'(bus.fifo_empty), 1);

        // simultaneous push and pop
        for (int i = 1; i <= 5; i++) push_rx(8'(8'h50 + i));
        ticks(20);
        chk("t4_level5", 32'(bus.level), 5);
        push_rx(8'h56);
        tick();
        chk("t4_uld", 32'(bus.uld_rx_data), 1);
        tick();
        pop();
        chk("t4_level_same", 32'(bus.level), 5);
        chk("t4_head", 32'(bus.rd_data), 32'h52);
        do_flush();
        chk("t4_flushed", 32'(bus.level), 0);

        // flush during capture
        for (int i = 1; i <= 3; i++) push_rx(8'(8'h60 + i));
        ticks(12);
        chk("t5_level3", 32'(bus.level), 3);
        push_rx(8'h77);
        tick();
        tick();
        do_flush();
        chk("t5_level", 32'(bus.level), 0);
        chk("t5_empty", 32'(bus.fifo_empty), 1);
        chk("t5_stalled", 32'(bus.stalled), 0);
        chk("t5_uld", 32'(bus.uld_rx_data), 0);
        push_rx(8'h3C);
        tick();
        chk("t5_idle_uld", 32'(bus.uld_rx_data), 1);
        tick();
        tick();
        chk("t5_lvl1", 32'(bus.level), 1);
        chk("t5_data", 32'(bus.rd_data), 32'h3C);

        // reset during unload
        push_rx(8'h99);
        tick();
        chk("t6_uld_hi", 32'(bus.uld_rx_data), 1);
        #2 reset = 1'b1;
        #1;
        chk("t6_uld_async", 32'(bus.uld_rx_data), 0);
        chk("t6_level", 32'(bus.level), 0);
        chk("t6_empty", 32'(bus.fifo_empty), 1);
        tick();
        reset = 1'b0;
        tick();
        chk("t6_resume_uld", 32'(bus.uld_rx_data), 1);
        tick();
        tick();
        chk("t6_lvl1", 32'(bus.level), 1);
        chk("t6_data", 32'(bus.rd_data), 32'h99);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive-side buffer that sits directly downstream of the UART receiver, in the rxclk domain.
- Watches the receiver's rx_empty flag and issues single-cycle uld_rx_data pulses to unload each received byte.
- Captures the resulting rx_data into a DEPTH-entry FIFO and presents bytes to the host with a first-word-fall-through read interface.
- Applies backpressure: when the FIFO is full it stops unloading, leaving the byte in the receiver.

Parameters:
- DEPTH, 16, number of FIFO entries; must be a power of two, at least 2.
- ADDR_W, 4, pointer width; must equal log2(DEPTH).

Ports:
- reset  input  1  asynchronous, active-high reset.
- rxclk  input  1  receive clock; all state is on its rising edge.
- unload_en  input  1  when high, the unload FSM may start new unloads.
- flush  input  1  synchronous FIFO clear; one-cycle pulse or held.
- rx_empty_i  input  1  receiver's rx_empty; 0 means a byte is pending.
- rx_data_i  input  8  receiver's rx_data; valid the cycle after uld_rx_data is sampled.
- uld_rx_data  output  1  registered unload strobe to the receiver.
- rd_en  input  1  host pop request.
- rd_data  output  8  head-of-FIFO byte; combinational from storage; valid when fifo_empty=0.
- fifo_empty  output  1  FIFO holds no bytes.
- fifo_full  output  1  FIFO holds DEPTH bytes.
- level  output  ADDR_W+1  current occupancy, 0..DEPTH.
- stalled  output  1  sticky flag: set when a byte was pending while the FIFO was full.

Behaviour:
- Reset values (asynchronous):
  - FSM in IDLE, pointers 0, level 0, storage contents don't-care.
  - uld_rx_data=0, fifo_empty=1, fifo_full=0, stalled=0.
- FSM states: IDLE, UNLOAD, CAPTURE.
  - IDLE -> UNLOAD when unload_en=1, rx_empty_i=0, fifo_full=0 and flush=0. uld_rx_data is registered high for exactly the UNLOAD cycle.
  - UNLOAD -> CAPTURE unconditionally. The receiver samples the strobe at the UNLOAD->CAPTURE edge and updates rx_data/rx_empty at that edge.
  - CAPTURE: rx_data_i is written into mem[wr_ptr]; wr_ptr is incremented modulo DEPTH; the state returns to IDLE.
  - rx_empty_i is not examined in UNLOAD or CAPTURE.
  - A byte that reappears as pending in CAPTURE (receiver completed a new frame at the unload edge) is picked up by the next IDLE evaluation. Minimum spacing is 3 cycles per byte.
- Full gating: IDLE checks fifo_full only. A slot is reserved at IDLE exit, so CAPTURE never writes a full FIFO. Implement this by counting an in-flight byte: IDLE's full test uses level plus the in-flight byte. No write-when-full can occur.
- stalled: set when IDLE sees rx_empty_i=0, unload_en=1 and the FIFO is full. Cleared only by reset or flush.
- Read side:
  - rd_data=mem[rd_ptr].
  - rd_en=1 with fifo_empty=0 increments rd_ptr modulo DEPTH.
  - rd_en with fifo_empty=1 is ignored: no pointer change and no error.
- Level arithmetic:
  - Write only: level+1. Read only: level-1. Write and read in the same cycle: level unchanged, both pointers advance.
  - fifo_empty=(level==0) and fifo_full=(level==DEPTH); both are registered or derived from the registered level.
- Wrap-around: pointers are ADDR_W bits and wrap naturally; level disambiguates full from empty.
- flush (priority over all FIFO activity):
  - Next edge: pointers=0, level=0, stalled=0.
  - FSM returns to IDLE; a byte in UNLOAD or CAPTURE is discarded, and uld_rx_data already issued is not retracted.
  - A rd_en in the flush cycle is ignored.
- unload_en=0 blocks new unloads only; an unload already in progress completes through CAPTURE.
- Reset mid-operation: immediate return to reset values. uld_rx_data drops asynchronously.

Test Plan:
- Single byte: reset, rx_empty_i 1->0 with rx_data_i=0xA5 after the strobe. Required: uld_rx_data high exactly 1 cycle; 2 cycles later level=1, fifo_empty=0, rd_data=0xA5; rd_en pulse -> level=0, fifo_empty=1.
- Fill to full: DEPTH=16, feed 0x00..0x10 (17 bytes), no reads. Required: level=16, fifo_full=1, no 17th strobe, stalled=1. Then pop one (rd_data=0x00) -> 17th byte 0x10 unloaded; reads return 0x01..0x10 in order.
- Wrap-around: 40 bytes with an interleaved pop every 4 cycles. Required: output sequence equals input sequence and level never exceeds 16.
- Simultaneous push/pop: with level=5, rd_en high on a CAPTURE cycle. Required: level stays 5 and the next head equals the 2nd oldest byte.
- Flush during CAPTURE: with level=3, assert flush on the CAPTURE cycle. Required: level=0, fifo_empty=1, stalled=0, FSM in IDLE next cycle; a subsequent byte 0x3C is read correctly.
- Reset mid-UNLOAD: assert reset while uld_rx_data=1. Required: uld_rx_data=0 immediately, level=0, fifo_empty=1; after deassert and rx_empty_i=0, normal unload resumes.
